// File: rtl/bm_mem.sv
// bm_mem: bitmatrix column store. The host streams narrow words that are
// assembled into one column and committed atomically; the bitmatrix
// controller reads whole columns with a one-cycle registered response.
// Reads always win the single array port over a pending commit.
// BM_MEM_ADDR_W may be set wider than $clog2(M_MAX) so that out-of-range
// column numbers are representable; those are rejected or read as zero.
// M_MAX must be at least 2.
module bm_mem #(
  parameter int K_MAX         = 128,
  parameter int M_MAX         = 128,
  parameter int W             = 4,
  parameter int HOST_W        = 32,
  parameter int BM_COL_W      = W * W * K_MAX,
  parameter int BM_MEM_ADDR_W = $clog2(M_MAX),
  parameter int WORDS_PER_COL = BM_COL_W / HOST_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     host_bm_wr_start,
  input  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_col,
  input  logic                     host_bm_wr_en,
  input  logic [HOST_W-1:0]        host_bm_wr_data,
  output logic                     bm_mem_host_wr_rdy,
  output logic                     bm_mem_host_col_done,
  output logic                     bm_mem_host_err,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val
);

  localparam int IDX_W = $clog2(M_MAX);
  localparam int CNT_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_COL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [CNT_W-1:0]         cnt;
  logic [BM_MEM_ADDR_W-1:0] wr_addr;
  logic [BM_COL_W-1:0]      asm_buf;
  logic [BM_COL_W-1:0]      mem [M_MAX];

  logic wr_col_ok;
  logic rd_addr_ok;
  logic start_ok;
  logic start_bad;
  logic word_acc;
  logic last_word;
  logic commit_we;

  // Range checks only exist when the address field can exceed the array.
  generate
    if (M_MAX >= (1 << BM_MEM_ADDR_W)) begin : g_full_range
      assign wr_col_ok  = 1'b1;
      assign rd_addr_ok = 1'b1;
    end else begin : g_partial_range
      assign wr_col_ok  = host_bm_wr_col < BM_MEM_ADDR_W'(M_MAX);
      assign rd_addr_ok = bm_cntl_bm_mem_rd_addr < BM_MEM_ADDR_W'(M_MAX);
    end
  endgenerate

  assign start_ok  = host_bm_wr_start && (state == IDLE) && wr_col_ok;
  assign start_bad = host_bm_wr_start && !((state == IDLE) && wr_col_ok);
  assign word_acc  = (state == FILL) && host_bm_wr_en;
  assign last_word = word_acc && (cnt == LAST_CNT);

  // Load FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode, host ready and the commit strobe (yields to reads).
  always_comb begin
    state_n            = state;
    commit_we          = 1'b0;
    bm_mem_host_wr_rdy = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_n = FILL;
      end
      FILL: begin
        bm_mem_host_wr_rdy = 1'b1;
        if (last_word) state_n = COMMIT;
      end
      COMMIT: begin
        if (!bm_cntl_bm_mem_rd_rq) begin
          commit_we = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Column assembly, target address latch and host status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt                  <= '0;
      wr_addr              <= '0;
      asm_buf              <= '0;
      bm_mem_host_col_done <= 1'b0;
      bm_mem_host_err      <= 1'b0;
    end else begin
      bm_mem_host_col_done <= commit_we;
      bm_mem_host_err      <= start_bad;
      if (start_ok) begin
        wr_addr <= host_bm_wr_col;
        cnt     <= '0;
        asm_buf <= '0;
      end else if (word_acc) begin
        asm_buf[cnt*HOST_W +: HOST_W] <= host_bm_wr_data;
        cnt <= last_word ? '0 : cnt + 1'b1;
      end
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_we) mem[wr_addr[IDX_W-1:0]] <= asm_buf;
  end

  // Registered read response; data holds between reads, only valid drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bm_mem_bm_cntl_rd_data     <= '0;
      bm_mem_bm_cntl_rd_data_val <= 1'b0;
    end else begin
      bm_mem_bm_cntl_rd_data_val <= bm_cntl_bm_mem_rd_rq;
      if (bm_cntl_bm_mem_rd_rq) begin
        bm_mem_bm_cntl_rd_data <= rd_addr_ok ? mem[bm_cntl_bm_mem_rd_addr[IDX_W-1:0]]
                                             : '0;
      end
    end
  end

endmodule

// File: tb/tb_bm_mem.sv
// tb_bm_mem: scoreboard bench for bm_mem with a 4-column, 32-bit array
// loaded through 8-bit host words. Expected read data is queued when a
// request is driven and compared by a monitor when rd_data_val appears.
module tb_bm_mem;

  localparam int K_MAX  = 2;
  localparam int M_MAX  = 4;
  localparam int W      = 4;
  localparam int HOST_W = 8;
  localparam int COL_W  = 32;
  localparam int AW     = 3;
  localparam int WPC    = 4;

  logic              clk;
  logic              rstn;
  logic              wr_start;
  logic [AW-1:0]     wr_col;
  logic              wr_en;
  logic [HOST_W-1:0] wr_data;
  logic              wr_rdy;
  logic              col_done;
  logic              err;
  logic              rd_rq;
  logic [AW-1:0]     rd_addr;
  logic [COL_W-1:0]  rd_data;
  logic              rd_val;

  int checks = 0;
  int errors = 0;

  logic [COL_W-1:0] sb [$];
  logic [COL_W-1:0] model [M_MAX];
  logic [COL_W-1:0] mon_exp;

  bm_mem #(
    .K_MAX(K_MAX), .M_MAX(M_MAX), .W(W), .HOST_W(HOST_W), .BM_MEM_ADDR_W(AW)
  ) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .host_bm_wr_start           (wr_start),
    .host_bm_wr_col             (wr_col),
    .host_bm_wr_en              (wr_en),
    .host_bm_wr_data            (wr_data),
    .bm_mem_host_wr_rdy         (wr_rdy),
    .bm_mem_host_col_done       (col_done),
    .bm_mem_host_err            (err),
    .bm_cntl_bm_mem_rd_rq       (rd_rq),
    .bm_cntl_bm_mem_rd_addr     (rd_addr),
    .bm_mem_bm_cntl_rd_data     (rd_data),
    .bm_mem_bm_cntl_rd_data_val (rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every valid read response must match the queue head.
  always @(negedge clk) begin
    if (rd_val === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_unexpected_val: val=1 with nothing outstanding, rd_data=%h", rd_data);
      end else begin
        mon_exp = sb.pop_front();
        if (rd_data !== mon_exp) begin
          errors++;
          $display("[TB] FAIL rd_data: got %h expected %h", rd_data, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic read_push(input logic [AW-1:0] addr);
    rd_rq   = 1'b1;
    rd_addr = addr;
    sb.push_back((addr < M_MAX) ? model[addr[1:0]] : '0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    @(negedge clk);
    read_push(addr);
    @(negedge clk);
    rd_rq = 1'b0;
    checks++;
    if (rd_val !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_val addr=%0d: got %b expected 1", addr, rd_val);
    end
  endtask

  // Load one column; optional gaps between words, a stray start at word
  // index 'glitch', and 'stall' read cycles of the same column after the
  // last word (each delays col_done by one cycle and returns old data).
  task automatic load_column(input logic [AW-1:0] col, input logic [COL_W-1:0] data,
                             input int gap, input int glitch, input int stall);
    logic [COL_W-1:0] d;
    d = data;
    @(negedge clk);
    wr_start = 1'b1;
    wr_col   = col;
    @(negedge clk);
    wr_start = 1'b0;
    checks++;
    if (wr_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_rdy_after_start col=%0d: got %b expected 1", col, wr_rdy);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_err_after_start col=%0d: got %b expected 0", col, err);
    end
    for (int k = 0; k < WPC; k++) begin
      wr_en   = 1'b1;
      wr_data = d[k*HOST_W +: HOST_W];
      if (k == glitch) begin
        wr_start = 1'b1;
        wr_col   = col ^ 3'd1;
      end
      @(negedge clk);
      wr_en    = 1'b0;
      wr_start = 1'b0;
      wr_data  = 8'hA5;
      checks++;
      if (err !== (k == glitch)) begin
        errors++;
        $display("[TB] FAIL load_err word=%0d: got %b expected %b", k, err, (k == glitch));
      end
      checks++;
      if (wr_rdy !== (k < WPC - 1)) begin
        errors++;
        $display("[TB] FAIL load_rdy word=%0d: got %b expected %b", k, wr_rdy, (k < WPC - 1));
      end
      if (k < WPC - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (wr_rdy !== 1'b1 || col_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_gap word=%0d: rdy=%b done=%b expected rdy=1 done=0", k, wr_rdy, col_done);
          end
        end
      end
    end
    checks++;
    if (col_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_early col=%0d: got %b expected 0", col, col_done);
    end
    for (int s = 0; s < stall; s++) begin
      read_push(col);
      @(negedge clk);
      checks++;
      if (col_done !== 1'b0 || wr_rdy !== 1'b0 || rd_val !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall cycle=%0d: done=%b rdy=%b val=%b expected 0 0 1", s, col_done, wr_rdy, rd_val);
      end
    end
    rd_rq = 1'b0;
    @(negedge clk);
    checks++;
    if (col_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL col_done col=%0d: got %b expected 1", col, col_done);
    end
    model[col[1:0]] = data;
    @(negedge clk);
    checks++;
    if (col_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL col_done_pulse col=%0d: got %b expected 0", col, col_done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wr_start = 1'b0; wr_col = '0; wr_en = 1'b0; wr_data = '0;
    rd_rq = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_rdy, col_done, err, rd_val} !== 4'b0 || rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rdy=%b done=%b err=%b val=%b data=%h expected all 0",
               wr_rdy, col_done, err, rd_val, rd_data);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_read();
    load_column(3'd2, 32'h44332211, 0, -1, 0);
    do_read(3'd2);
    @(negedge clk);
    checks++;
    if (rd_val !== 1'b0 || rd_data !== 32'h44332211) begin
      errors++;
      $display("[TB] FAIL read_hold: val=%b data=%h expected 0 44332211", rd_val, rd_data);
    end
  endtask

  task automatic test_commit_stall();
    load_column(3'd0, 32'h0A0B0C0D, 0, -1, 0);
    load_column(3'd0, 32'h5A6B7C8D, 0, -1, 3);
    do_read(3'd0);
  endtask

  task automatic test_gaps();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h77;
      @(negedge clk);
      checks++;
      if (wr_rdy !== 1'b0 || col_done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_wr_en: rdy=%b done=%b err=%b expected 0 0 0", wr_rdy, col_done, err);
      end
    end
    wr_en = 1'b0;
    load_column(3'd3, 32'hDEADBEEF, 2, -1, 0);
    do_read(3'd3);
  endtask

  task automatic test_errors();
    load_column(3'd1, 32'h99887766, 0, 1, 0);
    do_read(3'd1);
    do_read(3'd0);
    @(negedge clk);
    wr_start = 1'b1;
    wr_col   = 3'd4;
    @(negedge clk);
    wr_start = 1'b0;
    wr_en    = 1'b1;
    wr_data  = 8'h5C;
    checks++;
    if (err !== 1'b1 || wr_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_col_err: err=%b rdy=%b expected 1 0", err, wr_rdy);
    end
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (err !== 1'b0 || wr_rdy !== 1'b0 || col_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_col_idle: err=%b rdy=%b done=%b expected 0 0 0", err, wr_rdy, col_done);
    end
    do_read(3'd4);
    do_read(3'd7);
  endtask

  task automatic test_reset_mid();
    load_column(3'd1, 32'hAABBCCDD, 0, -1, 0);
    @(negedge clk);
    wr_start = 1'b1;
    wr_col   = 3'd1;
    @(negedge clk);
    wr_start = 1'b0;
    wr_en    = 1'b1;
    wr_data  = 8'h11;
    @(negedge clk);
    wr_data  = 8'h22;
    @(negedge clk);
    wr_en    = 1'b0;
    rd_rq    = 1'b1;
    rd_addr  = 3'd1;
    #1 rstn  = 1'b0;
    #1;
    checks++;
    if ({wr_rdy, col_done, err, rd_val} !== 4'b0 || rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL midload_reset: rdy=%b done=%b err=%b val=%b data=%h expected all 0",
               wr_rdy, col_done, err, rd_val, rd_data);
    end
    @(negedge clk);
    checks++;
    if (rd_val !== 1'b0 || wr_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pending_read: val=%b rdy=%b expected 0 0", rd_val, wr_rdy);
    end
    rd_rq = 1'b0;
    rstn  = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_rdy !== 1'b0 || col_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: rdy=%b done=%b expected 0 0", wr_rdy, col_done);
    end
    do_read(3'd1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [5];
    addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    load_column(3'd0, 32'h01234567, 0, -1, 0);
    load_column(3'd1, 32'h89ABCDEF, 0, -1, 0);
    load_column(3'd2, 32'h13579BDF, 0, -1, 0);
    load_column(3'd3, 32'h2468ACE0, 0, -1, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      read_push(addrs[i]);
      @(negedge clk);
      checks++;
      if (rd_val !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sweep_val idx=%0d: got %b expected 1", i, rd_val);
      end
    end
    rd_rq = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_val !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_end_val: got %b expected 0", rd_val);
    end
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_commit_stall();
    test_gaps();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bm_mem.md
# bm_mem

Bitmatrix column storage and responder for the bitmatrix controller's read interface. It holds up to M_MAX bitmatrix columns of BM_COL_W bits each. The host loads each column as a sequence of narrow words that the block assembles into one column and commits atomically. The bitmatrix controller issues single-column read requests, and this block answers each one with data and a one-cycle valid.

## Interface
- K_MAX, 128, max data-chunk count
- M_MAX, 128, max parity count = column count
- W, 4, GF word width
- HOST_W, 32, host load word width; BM_COL_W must be a multiple of HOST_W
- BM_COL_W, W*W*K_MAX, column width (derived)
- BM_MEM_ADDR_W, $clog2(M_MAX), column address width (derived)
- WORDS_PER_COL, BM_COL_W/HOST_W, host words per column (derived)
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- host_bm_wr_start  in  1  begin loading column host_bm_wr_col
- host_bm_wr_col  in  BM_MEM_ADDR_W  target column, sampled with start
- host_bm_wr_en  in  1  host word valid; honoured only while bm_mem_host_wr_rdy=1
- host_bm_wr_data  in  HOST_W  host word
- bm_mem_host_wr_rdy  out  1  block accepts host words
- bm_mem_host_col_done  out  1  one-cycle pulse: column committed to the array
- bm_mem_host_err  out  1  one-cycle pulse: start rejected
- bm_cntl_bm_mem_rd_rq  in  1  read request
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  column to read
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  column data
- bm_mem_bm_cntl_rd_data_val  out  1  rd_data valid, one cycle per request

## Operation
- Storage: M_MAX x BM_COL_W array with one access per cycle, shared by read and commit. Contents are not reset, and a column is undefined until it is loaded.
- Load FSM states: IDLE, FILL, COMMIT.
  - IDLE: on start with host_bm_wr_col < M_MAX, latch the address, clear the word counter and the assembly buffer, then go to FILL. If host_bm_wr_col >= M_MAX, pulse err and stay in IDLE.
  - FILL: wr_rdy=1. Each wr_en writes host_bm_wr_data into buffer[cnt*HOST_W +: HOST_W], so word 0 lands in the LSBs, and then increments cnt. When the word with cnt = WORDS_PER_COL-1 is accepted, go to COMMIT; that transition deasserts wr_rdy in the next cycle.
  - COMMIT: wr_rdy=0. If rd_rq=0 this cycle, write the buffer into array[addr], pulse col_done in the next cycle, and go to IDLE. If rd_rq=1, stay in COMMIT; the commit stalls and no buffer data is lost.
- A start received in FILL or COMMIT is ignored: pulse err, and the load in progress continues unchanged.
- wr_en outside FILL is ignored without error.
- Read: when rd_rq=1, return array[rd_addr] as registered rd_data. If rd_addr >= M_MAX, return all zeros; val is still asserted.
- rd_data holds its last value when no read is in progress; only val deasserts.
- Read has priority over commit. A read of the column being committed in the same cycle cannot occur, because the commit yields to the read.
- Back-to-back rd_rq on consecutive cycles returns back-to-back data, one column per cycle.

## Timing
- Read latency: 1 cycle. A request at edge N gives val=1 and rd_data valid during cycle N+1. val drops in N+2 unless another request arrives at N+1.
- Load: a start at edge N gives wr_rdy=1 in cycle N+1. The last word accepted at edge L gives the commit at edge L+1 when rd_rq=0, and col_done=1 during cycle L+2. Each cycle of rd_rq in COMMIT delays the commit and col_done by one cycle.
- A read issued after col_done returns the new column. A read issued before or during COMMIT returns the old contents.
- err: pulse in the cycle after the rejected start.
- Reset values: rd_data=0, rd_data_val=0, wr_rdy=0, col_done=0, err=0, FSM=IDLE, cnt=0.
- Reset mid-load (rstn low in FILL or COMMIT): the partial or uncommitted column is discarded, and the array entry keeps its prior contents. A read pending at reset gets no val.

## Test plan
Bench parameters: K_MAX=2, M_MAX=4, W=4, HOST_W=8, giving BM_COL_W=32 and WORDS_PER_COL=4.

- Load and read:
  - Stimulus: start col 2, then words 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Response: col_done 2 cycles after the last word.
  - Then rd_rq with addr 2. Response: next cycle val=1 and rd_data=0x44332211.
- Commit stall:
  - Stimulus: hold rd_rq=1 with addr 0 for 3 cycles as the last word is accepted.
  - Response: three back-to-back vals carrying the old col 0 data; col_done arrives 3 cycles late.
  - Then read col 0. Response: the new data.
- Host backpressure and gaps: insert wr_en=0 gaps between words -> gaps do not count, and exactly 4 accepted words are required. wr_en while in IDLE -> ignored.
- Errors:
  - start during FILL -> err pulse, and the original load completes with correct data.
  - start with col 4 -> err pulse, FSM stays IDLE, wr_rdy stays 0.
- Reset mid-load:
  - Stimulus: load col 1 = 0xAABBCCDD, start reloading col 1, apply rstn low after 2 words.
  - Response: all outputs reset, and a read of col 1 returns 0xAABBCCDD.
- Read sweep: load cols 0-3 with distinct patterns, then issue rd_rq every cycle for addr 0,1,2,3,0.
  - Response: 5 consecutive vals with matching data and no bubbles.
